// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: byte stream from the UART receiver in,
// register-write strobe and error status out.
interface uart_cmd_parser_if;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        reg_wr_en;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        frame_err;
   logic [7:0]  err_count;
   logic        busy;
   modport master (
      output rx_byte, rx_valid,
      input  reg_wr_en, reg_addr, reg_wdata, frame_err, err_count, busy
   );
   modport slave (
      input  rx_byte, rx_valid,
      output reg_wr_en, reg_addr, reg_wdata, frame_err, err_count, busy
   );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames sync/addr/4 data/xor bytes into register writes,
// flagging and counting checksum failures and inter-byte timeouts.
module uart_cmd_parser #(
   parameter int         CLKS_TIMEOUT = 50000,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input logic               clk,
   input logic               reset_n,
   uart_cmd_parser_if.slave  io_bus
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, CSUM} state_t;
   localparam logic [19:0] IDLE_MAX = 20'(CLKS_TIMEOUT - 1);

   state_t      r_state;
   logic [19:0] r_idle;
   logic [1:0]  r_idx;
   logic [7:0]  r_addr_sh;
   logic [31:0] r_data_sh;
   logic [7:0]  r_csum;
   logic        r_wr_en;
   logic        r_err;
   logic [7:0]  r_err_count;
   logic [7:0]  r_addr;
   logic [31:0] r_wdata;
   logic        r_busy;

   logic        w_valid;
   logic [7:0]  w_byte;
   logic        w_expire;
   logic [7:0]  w_err_next;

   assign w_valid    = io_bus.rx_valid;
   assign w_byte     = io_bus.rx_byte;
   // A byte arriving on the expiry cycle wins over the timeout.
   assign w_expire   = !w_valid && r_idle == IDLE_MAX;
   assign w_err_next = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_idle      <= '0;
         r_idx       <= '0;
         r_addr_sh   <= '0;
         r_data_sh   <= '0;
         r_csum      <= '0;
         r_wr_en     <= 1'b0;
         r_err       <= 1'b0;
         r_err_count <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_err   <= 1'b0;
         if (r_state == IDLE) begin
            r_idle <= '0;
            if (w_valid && w_byte == SYNC_BYTE) begin
               r_state <= ADDR;
               r_busy  <= 1'b1;
            end
         end else if (w_expire) begin
            r_err       <= 1'b1;
            r_err_count <= w_err_next;
            r_idle      <= '0;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
         end else if (!w_valid) begin
            r_idle <= r_idle + 20'd1;
         end else begin
            r_idle <= '0;
            case (r_state)
               ADDR: begin
                  r_addr_sh <= w_byte;
                  r_csum    <= w_byte;
                  r_idx     <= '0;
                  r_state   <= DATA;
               end
               DATA: begin
                  // Shifting in from the bottom leaves byte 0 in [31:24].
                  r_data_sh <= {r_data_sh[23:0], w_byte};
                  r_csum    <= r_csum ^ w_byte;
                  r_idx     <= r_idx + 2'd1;
                  if (r_idx == 2'd3) r_state <= CSUM;
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  if (w_byte == r_csum) begin
                     r_wr_en <= 1'b1;
                     r_addr  <= r_addr_sh;
                     r_wdata <= r_data_sh;
                  end else begin
                     r_err       <= 1'b1;
                     r_err_count <= w_err_next;
                  end
               end
            endcase
         end
      end
   end

   assign io_bus.reg_wr_en = r_wr_en;
   assign io_bus.reg_addr  = r_addr;
   assign io_bus.reg_wdata = r_wdata;
   assign io_bus.frame_err = r_err;
   assign io_bus.err_count = r_err_count;
   assign io_bus.busy      = r_busy;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and randomized frames against a frame-level
// model of expected commits, error pulses and error count.
module tb_uart_cmd_parser;
   localparam int CT = 100;
   typedef logic [0:6][7:0] frame_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   uart_cmd_parser_if bus();

   uart_cmd_parser #(.CLKS_TIMEOUT(CT), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .reset_n(reset_n), .io_bus(bus)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int cyc = 0, wr_cnt = 0, err_cnt = 0, both_cnt = 0;
   int last_wr_cyc = 0, last_err_cyc = 0, csum_cyc = 0;
   logic busy_at_err = 1'b0, busy_at_wr = 1'b0;
   logic [39:0] wr_log[$];
   int wr_cyc_log[$];

   logic [7:0]  exp_addr = 8'h00, exp_errc = 8'h00;
   logic [31:0] exp_data = 32'h0;
   int exp_wr = 0, exp_errp = 0;

   initial forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.reg_wr_en) begin
         wr_cnt++;
         last_wr_cyc = cyc;
         busy_at_wr = bus.busy;
         wr_log.push_back({bus.reg_addr, bus.reg_wdata});
         wr_cyc_log.push_back(cyc);
      end
      if (bus.frame_err) begin
         err_cnt++;
         last_err_cyc = cyc;
         busy_at_err = bus.busy;
      end
      if (bus.reg_wr_en && bus.frame_err) both_cnt++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic drive(input logic [7:0] b);
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.rx_valid = 1'b0;
         bus.rx_byte  = 8'($urandom);
      end
   endtask

   function automatic frame_t make_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] flip);
      frame_t f;
      f[0] = 8'hA5;
      f[1] = a;
      f[2] = d[31:24];
      f[3] = d[23:16];
      f[4] = d[15:8];
      f[5] = d[7:0];
      f[6] = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0] ^ flip;
      return f;
   endfunction

   task automatic model_frame(input frame_t f);
      logic [7:0] x;
      x = f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5];
      if (f[6] == x) begin
         exp_wr++;
         exp_addr = f[1];
         exp_data = {f[2], f[3], f[4], f[5]};
      end else begin
         exp_errp++;
         if (exp_errc != 8'hFF) exp_errc++;
      end
   endtask

   task automatic send_frame(input frame_t f, input int maxgap);
      for (int i = 0; i < 7; i++) begin
         drive(f[i]);
         if (i == 6) csum_cyc = cyc + 1;
         else if (maxgap > 0) idle($urandom_range(maxgap, 0));
      end
      model_frame(f);
   endtask

   task automatic test_reset();
      idle(2);
      tests++; if (bus.busy !== 1'b0 || bus.reg_wr_en !== 1'b0 || bus.frame_err !== 1'b0) begin
         fails++; $display("FAIL reset_strobes: busy=%b wr=%b err=%b want 0 0 0", bus.busy, bus.reg_wr_en, bus.frame_err);
      end
      tests++; if (bus.err_count !== 8'h00) begin
         fails++; $display("FAIL reset_err_count: got %h want 00", bus.err_count);
      end
      tests++; if (bus.reg_addr !== 8'h00 || bus.reg_wdata !== 32'h0) begin
         fails++; $display("FAIL reset_regs: got %h %h want 00 00000000", bus.reg_addr, bus.reg_wdata);
      end
      @(negedge clk);
      reset_n = 1'b1;
      idle(2);
   endtask

   task automatic test_valid_frame();
      frame_t f;
      int w0;
      f  = {8'hA5, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h32};
      w0 = wr_cnt;
      drive(f[0]);
      drive(f[1]);
      tests++; if (bus.busy !== 1'b1) begin
         fails++; $display("FAIL busy_after_sync: got %b want 1", bus.busy);
      end
      for (int i = 2; i < 7; i++) drive(f[i]);
      csum_cyc = cyc + 1;
      model_frame(f);
      idle(3);
      tests++; if (wr_cnt - w0 !== 1 || err_cnt !== 0) begin
         fails++; $display("FAIL valid_pulses: wr=%0d err=%0d want 1 0", wr_cnt - w0, err_cnt);
      end
      tests++; if (bus.reg_addr !== 8'h10 || bus.reg_wdata !== 32'hDEADBEEF) begin
         fails++; $display("FAIL valid_regs: got %h %h want 10 deadbeef", bus.reg_addr, bus.reg_wdata);
      end
      tests++; if (last_wr_cyc !== csum_cyc || busy_at_wr !== 1'b0) begin
         fails++; $display("FAIL valid_latency: wr edge %0d busy %b want edge %0d busy 0", last_wr_cyc, busy_at_wr, csum_cyc);
      end
      tests++; if (bus.err_count !== 8'h00) begin
         fails++; $display("FAIL valid_err_count: got %h want 00", bus.err_count);
      end
   endtask

   task automatic test_bad_csum();
      int w0, e0;
      w0 = wr_cnt; e0 = err_cnt;
      send_frame(make_frame(8'h10, 32'hDEADBEEF, 8'h01), 0);
      idle(3);
      tests++; if (err_cnt - e0 !== 1 || wr_cnt !== w0 || last_err_cyc !== csum_cyc) begin
         fails++; $display("FAIL bad_csum_pulses: err=%0d wr=%0d edge %0d want 1 0 edge %0d", err_cnt - e0, wr_cnt - w0, last_err_cyc, csum_cyc);
      end
      tests++; if (bus.err_count !== 8'h01) begin
         fails++; $display("FAIL bad_csum_count: got %h want 01", bus.err_count);
      end
      tests++; if (bus.reg_addr !== 8'h10 || bus.reg_wdata !== 32'hDEADBEEF) begin
         fails++; $display("FAIL bad_csum_hold: got %h %h want 10 deadbeef", bus.reg_addr, bus.reg_wdata);
      end
   endtask

   task automatic test_prefix();
      int e0;
      e0 = err_cnt;
      drive(8'h00); drive(8'hFF); drive(8'h5A);
      idle(2);
      tests++; if (bus.busy !== 1'b0) begin
         fails++; $display("FAIL prefix_busy: got %b want 0", bus.busy);
      end
      send_frame({8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h07, 8'h06}, 0);
      idle(3);
      tests++; if (bus.reg_addr !== 8'h01 || bus.reg_wdata !== 32'h00000007) begin
         fails++; $display("FAIL prefix_regs: got %h %h want 01 00000007", bus.reg_addr, bus.reg_wdata);
      end
      tests++; if (err_cnt !== e0 || bus.err_count !== 8'h01) begin
         fails++; $display("FAIL prefix_errors: pulses %0d count %h want 0 01", err_cnt - e0, bus.err_count);
      end
   endtask

   task automatic test_timeout();
      int e0, w0, p;
      e0 = err_cnt;
      drive(8'hA5); drive(8'h10); drive(8'hDE);
      p = cyc + 1;
      for (int k = 0; k < 3 * CT && err_cnt == e0; k++) idle(1);
      exp_errp++;
      if (exp_errc != 8'hFF) exp_errc++;
      tests++; if (err_cnt - e0 !== 1) begin
         fails++; $display("FAIL timeout_fired: got %0d pulses want 1", err_cnt - e0);
      end
      tests++; if (last_err_cyc - p !== CT || busy_at_err !== 1'b0) begin
         fails++; $display("FAIL timeout_latency: %0d edges busy %b want %0d busy 0", last_err_cyc - p, busy_at_err, CT);
      end
      w0 = wr_cnt;
      send_frame(make_frame(8'($urandom), $urandom, 8'h00), 3);
      idle(3);
      tests++; if (wr_cnt - w0 !== 1 || bus.reg_addr !== exp_addr || bus.reg_wdata !== exp_data) begin
         fails++; $display("FAIL timeout_recover: wr=%0d regs %h %h want 1 %h %h", wr_cnt - w0, bus.reg_addr, bus.reg_wdata, exp_addr, exp_data);
      end
   endtask

   task automatic test_expiry_valid();
      frame_t f;
      int e0;
      e0 = err_cnt;
      f  = make_frame(8'h10, 32'hDEADBEEF, 8'h00);
      for (int i = 0; i < 3; i++) drive(f[i]);
      idle(CT - 1);
      for (int i = 3; i < 7; i++) drive(f[i]);
      model_frame(f);
      idle(3);
      tests++; if (err_cnt !== e0) begin
         fails++; $display("FAIL expiry_valid_err: got %0d pulses want 0", err_cnt - e0);
      end
      tests++; if (bus.reg_addr !== 8'h10 || bus.reg_wdata !== 32'hDEADBEEF) begin
         fails++; $display("FAIL expiry_valid_regs: got %h %h want 10 deadbeef", bus.reg_addr, bus.reg_wdata);
      end
   endtask

   task automatic test_back_to_back();
      frame_t f1, f2;
      int n0;
      f1 = make_frame(8'($urandom), $urandom, 8'h00);
      f2 = make_frame(8'($urandom), $urandom, 8'h00);
      n0 = wr_log.size();
      send_frame(f1, 0);
      send_frame(f2, 0);
      idle(3);
      tests++; if (wr_log.size() !== n0 + 2) begin
         fails++; $display("FAIL b2b_count: got %0d writes want 2", wr_log.size() - n0);
      end else begin
         tests++; if (wr_log[n0] !== {f1[1], f1[2], f1[3], f1[4], f1[5]}) begin
            fails++; $display("FAIL b2b_first: got %h want %h", wr_log[n0], {f1[1], f1[2], f1[3], f1[4], f1[5]});
         end
         tests++; if (wr_log[n0 + 1] !== {f2[1], f2[2], f2[3], f2[4], f2[5]}) begin
            fails++; $display("FAIL b2b_second: got %h want %h", wr_log[n0 + 1], {f2[1], f2[2], f2[3], f2[4], f2[5]});
         end
         tests++; if (wr_cyc_log[n0 + 1] - wr_cyc_log[n0] !== 7) begin
            fails++; $display("FAIL b2b_spacing: got %0d want 7", wr_cyc_log[n0 + 1] - wr_cyc_log[n0]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] j, flip;
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(3, 0)) begin
            j = 8'($urandom);
            drive(j == 8'hA5 ? 8'h00 : j);
            idle($urandom_range(2, 0));
         end
         flip = ($urandom_range(2, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00;
         send_frame(make_frame(8'($urandom), $urandom, flip), (n % 5 == 0) ? CT - 10 : 4);
         idle(2);
         tests++; if (bus.reg_addr !== exp_addr || bus.reg_wdata !== exp_data || bus.err_count !== exp_errc) begin
            fails++; $display("FAIL random_%0d: got %h %h %h want %h %h %h", n, bus.reg_addr, bus.reg_wdata, bus.err_count, exp_addr, exp_data, exp_errc);
         end
      end
      tests++; if (wr_cnt !== exp_wr || err_cnt !== exp_errp) begin
         fails++; $display("FAIL random_totals: wr %0d err %0d want %0d %0d", wr_cnt, err_cnt, exp_wr, exp_errp);
      end
   endtask

   task automatic test_reset_mid_and_saturate();
      int w0, e0;
      w0 = wr_cnt; e0 = err_cnt;
      drive(8'hA5); drive(8'h10);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      tests++; if (bus.busy !== 1'b0) begin
         fails++; $display("FAIL reset_mid_async: busy %b want 0", bus.busy);
      end
      @(negedge clk);
      reset_n = 1'b1;
      exp_addr = 8'h00; exp_data = 32'h0; exp_errc = 8'h00;
      idle(3);
      tests++; if (bus.busy !== 1'b0 || wr_cnt !== w0 || err_cnt !== e0 || bus.err_count !== 8'h00) begin
         fails++; $display("FAIL reset_mid: busy %b wr %0d err %0d count %h want 0 0 0 00", bus.busy, wr_cnt - w0, err_cnt - e0, bus.err_count);
      end
      e0 = err_cnt;
      for (int n = 0; n < 256; n++)
         send_frame(make_frame(8'($urandom), $urandom, 8'($urandom_range(255, 1))), 0);
      idle(3);
      tests++; if (err_cnt - e0 !== 256 || wr_cnt !== w0) begin
         fails++; $display("FAIL saturate_pulses: err %0d wr %0d want 256 0", err_cnt - e0, wr_cnt - w0);
      end
      tests++; if (bus.err_count !== exp_errc || bus.err_count !== 8'hFF) begin
         fails++; $display("FAIL saturate_count: got %h want ff", bus.err_count);
      end
      tests++; if (bus.reg_addr !== 8'h00 || bus.reg_wdata !== 32'h0) begin
         fails++; $display("FAIL saturate_regs: got %h %h want 00 00000000", bus.reg_addr, bus.reg_wdata);
      end
      tests++; if (both_cnt !== 0) begin
         fails++; $display("FAIL exclusive_strobes: got %0d overlaps want 0", both_cnt);
      end
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'h00;
      test_reset();
      test_valid_frame();
      test_bad_csum();
      test_prefix();
      test_timeout();
      test_expiry_valid();
      test_back_to_back();
      test_random();
      test_reset_mid_and_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
